mem_wb_skid_reg: RTL

- Parametrised successor to the MEM/WB pipeline register.
- Carries RegWrite, write data, destination register and extra control bits from MEM to WB.
- Adds a valid/ready handshake with a 2-entry skid buffer, so WB backpressure never creates a combinational ready path into MEM.
- Adds synchronous flush and optional suppression of writes to register 0.

---
 rtl/mem_wb_skid_reg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_skid_reg.sv
// rtl/mem_wb_skid_reg.sv - MEM/WB pipeline register with 2-entry skid buffer, flush and x0 write suppression
module mem_wb_skid_reg #(
   parameter int DATA_W            = 32,
   parameter int ADDR_W            = 5,
   parameter int CTRL_W            = 4,
   parameter int ZERO_REG_SUPPRESS = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_regwrite,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_regwrite,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_rd,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   // State encoding doubles as occupancy; M valid = !EMPTY, S valid = FULL.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic              m_regwrite_q;
   logic [DATA_W-1:0] m_data_q;
   logic [ADDR_W-1:0] m_rd_q;
   logic [CTRL_W-1:0] m_ctrl_q;
   logic              s_regwrite_q;
   logic [DATA_W-1:0] s_data_q;
   logic [ADDR_W-1:0] s_rd_q;
   logic [CTRL_W-1:0] s_ctrl_q;

   logic accept;
   logic fire;
   logic capture_regwrite;
   logic m_load_in;
   logic m_load_skid;
   logic s_load;

   assign accept           = in_valid & (state_q != FULL);
   assign fire             = out_ready & (state_q != EMPTY);
   assign capture_regwrite = in_regwrite & ~((ZERO_REG_SUPPRESS != 0) && (in_rd == '0));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      m_load_in   = 1'b0;
      m_load_skid = 1'b0;
      s_load      = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d   = ONE;
               m_load_in = 1'b1;
            end
         end
         ONE: begin
            if (accept && fire) begin
               m_load_in = 1'b1;
            end else if (accept) begin
               state_d = FULL;
               s_load  = 1'b1;
            end else if (fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (fire) begin
               state_d     = ONE;
               m_load_skid = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      // Flush empties both entries; an entry accepted this cycle is dropped unwritten.
      if (flush) begin
         state_d     = EMPTY;
         m_load_in   = 1'b0;
         m_load_skid = 1'b0;
         s_load      = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m_regwrite_q <= 1'b0;
         m_data_q     <= '0;
         m_rd_q       <= '0;
         m_ctrl_q     <= '0;
         s_regwrite_q <= 1'b0;
         s_data_q     <= '0;
         s_rd_q       <= '0;
         s_ctrl_q     <= '0;
      end else begin
         if (m_load_in) begin
            m_regwrite_q <= capture_regwrite;
            m_data_q     <= in_data;
            m_rd_q       <= in_rd;
            m_ctrl_q     <= in_ctrl;
         end else if (m_load_skid) begin
            m_regwrite_q <= s_regwrite_q;
            m_data_q     <= s_data_q;
            m_rd_q       <= s_rd_q;
            m_ctrl_q     <= s_ctrl_q;
         end
         if (s_load) begin
            s_regwrite_q <= capture_regwrite;
            s_data_q     <= in_data;
            s_rd_q       <= in_rd;
            s_ctrl_q     <= in_ctrl;
         end
      end
   end

   always_comb begin
      in_ready     = (state_q != FULL);
      out_valid    = (state_q != EMPTY);
      out_regwrite = (state_q != EMPTY) & m_regwrite_q;
      out_data     = m_data_q;
      out_rd       = m_rd_q;
      out_ctrl     = m_ctrl_q;
      occupancy    = state_q;
   end

endmodule
